// File: rtl/caliptra_fdm_copy_ctrl.sv
// Copy sequencer for the FDM APB transfer engine: moves N dwords from FUSE to CPTRA
// as alternating single read/write transactions, with word-boundary abort and status.
module caliptra_fdm_copy_ctrl #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int CNT_WIDTH      = 8,
    parameter int ADDR_STRIDE    = 4
) (
    input  logic                      i_clk,
    input  logic                      i_resetn,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [APB_ADDR_WIDTH-1:0] i_src_base,
    input  logic [APB_ADDR_WIDTH-1:0] i_dst_base,
    input  logic [CNT_WIDTH-1:0]      i_num_words,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error,
    output logic                      o_aborted,
    output logic [CNT_WIDTH-1:0]      o_words_done,
    output logic                      o_apb_en,
    output logic                      o_apb_op,
    output logic [APB_ADDR_WIDTH-1:0] o_src_addr,
    output logic [APB_ADDR_WIDTH-1:0] o_dst_addr,
    output logic [APB_DATA_WIDTH-1:0] o_apb_wdata,
    input  logic                      i_apb_done,
    input  logic                      i_apb_error,
    input  logic [APB_DATA_WIDTH-1:0] i_apb_rdata
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_WAIT = 3'd4;
    localparam logic [2:0] FINISH  = 3'd5;

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic                 abort_pending;
    logic                 abort_req;
    logic                 last_word;
    logic                 zero_start;
    logic [CNT_WIDTH-1:0] num_words;
    logic [CNT_WIDTH-1:0] words_inc;

    assign words_inc  = o_words_done + CNT_WIDTH'(1);
    assign last_word  = (words_inc == num_words);
    assign abort_req  = abort_pending | i_abort;
    assign zero_start = (state == IDLE) && i_start && (i_num_words == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start && (i_num_words != '0)) state_nxt = RD_REQ;
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: if (i_apb_done) state_nxt = i_apb_error ? FINISH : WR_REQ;
            WR_REQ:  state_nxt = WR_WAIT;
            WR_WAIT: begin
                if (i_apb_done) begin
                    if (i_apb_error || last_word || abort_req) state_nxt = FINISH;
                    else                                       state_nxt = RD_REQ;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status/strobe outputs are decoded from the next state so they stay registered.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state    <= IDLE;
            o_busy   <= 1'b0;
            o_apb_en <= 1'b0;
            o_apb_op <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state    <= state_nxt;
            o_busy   <= (state_nxt != IDLE);
            o_apb_en <= (state_nxt == RD_REQ) || (state_nxt == WR_REQ);
            o_apb_op <= (state_nxt == WR_REQ) || (state_nxt == WR_WAIT);
            o_done   <= (state_nxt == FINISH) || zero_start;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            o_src_addr    <= '0;
            o_dst_addr    <= '0;
            num_words     <= '0;
            o_words_done  <= '0;
            o_apb_wdata   <= '0;
            o_error       <= 1'b0;
            o_aborted     <= 1'b0;
            abort_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_src_addr   <= i_src_base;
                        o_dst_addr   <= i_dst_base;
                        num_words    <= i_num_words;
                        o_words_done <= '0;
                        o_error      <= 1'b0;
                        o_aborted    <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (i_apb_done) begin
                        if (i_apb_error) o_error     <= 1'b1;
                        else             o_apb_wdata <= i_apb_rdata;
                    end
                end
                WR_WAIT: begin
                    if (i_apb_done) begin
                        if (i_apb_error) begin
                            o_error <= 1'b1;
                        end else begin
                            o_words_done <= words_inc;
                            o_src_addr   <= o_src_addr + APB_ADDR_WIDTH'(ADDR_STRIDE);
                            o_dst_addr   <= o_dst_addr + APB_ADDR_WIDTH'(ADDR_STRIDE);
                            // A finished final word wins over a pending abort.
                            if (!last_word && abort_req) o_aborted <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (state == FINISH)                 abort_pending <= 1'b0;
            else if (state != IDLE && i_abort)   abort_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_caliptra_fdm_copy_ctrl.sv
// Self-checking bench for caliptra_fdm_copy_ctrl: an APB engine responder records every
// transaction, and a per-job reference model predicts the traffic and final status.
module tb_caliptra_fdm_copy_ctrl;

    logic        i_clk = 1'b0;
    logic        i_resetn = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [31:0] i_src_base = '0;
    logic [31:0] i_dst_base = '0;
    logic [7:0]  i_num_words = '0;
    logic        o_busy, o_done, o_error, o_aborted, o_apb_en, o_apb_op;
    logic [7:0]  o_words_done;
    logic [31:0] o_src_addr, o_dst_addr, o_apb_wdata;
    logic        i_apb_done = 1'b0;
    logic        i_apb_error = 1'b0;
    logic [31:0] i_apb_rdata = '0;

    caliptra_fdm_copy_ctrl dut (
        .i_clk(i_clk), .i_resetn(i_resetn), .i_start(i_start), .i_abort(i_abort),
        .i_src_base(i_src_base), .i_dst_base(i_dst_base), .i_num_words(i_num_words),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_aborted(o_aborted),
        .o_words_done(o_words_done), .o_apb_en(o_apb_en), .o_apb_op(o_apb_op),
        .o_src_addr(o_src_addr), .o_dst_addr(o_dst_addr), .o_apb_wdata(o_apb_wdata),
        .i_apb_done(i_apb_done), .i_apb_error(i_apb_error), .i_apb_rdata(i_apb_rdata)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Current job description shared with the engine responder and the model
    logic [31:0] job_src, job_dst, job_base;
    int job_num, job_err_r, job_err_w, job_abort;
    int rd_idx, wr_idx;
    int eng_fixed = 0;
    bit eng_busy = 0;

    logic        rec_op[$];
    logic [31:0] rec_addr[$];
    logic [31:0] rec_data[$];
    logic        exp_op[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int exp_words;
    bit exp_err, exp_abort;

    int done_count = 0;
    int en_count = 0;
    int busy_count = 0;

    always @(negedge i_clk) begin
        if (o_done)   done_count++;
        if (o_apb_en) en_count++;
        if (o_busy)   busy_count++;
    end

    // APB engine responder: answers each enable pulse after 1..3 cycles (or a fixed delay)
    initial begin
        @(posedge i_clk); #1;
        forever begin
            if (o_apb_en) begin
                automatic logic        op = o_apb_op;
                automatic logic [31:0] addr = op ? o_dst_addr : o_src_addr;
                automatic bit          err;
                automatic int          n = (eng_fixed > 0) ? eng_fixed : int'($urandom_range(1, 3));
                eng_busy = 1;
                rec_op.push_back(op);
                rec_addr.push_back(addr);
                rec_data.push_back(op ? o_apb_wdata : 32'h0);
                err = op ? (wr_idx == job_err_w) : (rd_idx == job_err_r);
                if (!op && rd_idx == job_abort) i_abort = 1'b1;
                repeat (n) begin
                    @(posedge i_clk); #1;
                    i_abort = 1'b0;
                end
                i_apb_done  = 1'b1;
                i_apb_error = err;
                i_apb_rdata = (op || err) ? $urandom : job_base + ((addr - job_src) >> 2);
                @(posedge i_clk); #1;
                i_apb_done  = 1'b0;
                i_apb_error = 1'b0;
                i_apb_rdata = $urandom;
                if (op) wr_idx++; else rd_idx++;
                eng_busy = 0;
            end else begin
                @(posedge i_clk); #1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: word-by-word copy semantics with error and abort rules
    task automatic buildExpected();
        exp_op.delete(); exp_addr.delete(); exp_data.delete();
        exp_words = 0; exp_err = 0; exp_abort = 0;
        for (int i = 0; i < job_num; i++) begin
            exp_op.push_back(1'b0);
            exp_addr.push_back(job_src + 32'(4 * i));
            exp_data.push_back(32'h0);
            if (i == job_err_r) begin exp_err = 1; break; end
            exp_op.push_back(1'b1);
            exp_addr.push_back(job_dst + 32'(4 * i));
            exp_data.push_back(job_base + 32'(i));
            if (i == job_err_w) begin exp_err = 1; break; end
            exp_words = i + 1;
            if (i == job_abort && i != job_num - 1) begin exp_abort = 1; break; end
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] src, input logic [31:0] dst,
                                 input int num, input logic [31:0] base, input int err_r,
                                 input int err_w, input int abort_at, input bit busy_start);
        int d0, cycles;
        job_src = src; job_dst = dst; job_num = num; job_base = base;
        job_err_r = err_r; job_err_w = err_w; job_abort = abort_at;
        rd_idx = 0; wr_idx = 0;
        rec_op.delete(); rec_addr.delete(); rec_data.delete();
        buildExpected();
        @(negedge i_clk);
        d0 = done_count;
        i_start = 1'b1; i_src_base = src; i_dst_base = dst; i_num_words = 8'(num);
        @(negedge i_clk);
        i_start = 1'b0;
        cycles = 0;
        while (done_count == d0 && cycles < 3000) begin
            @(negedge i_clk);
            cycles++;
            if (busy_start && cycles == 3) begin
                i_start = 1'b1; i_src_base = 32'hDEAD0000; i_dst_base = 32'hBEEF0000; i_num_words = 8'd7;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        checkOutput({tag, "_done_seen"}, 64'(done_count != d0), 64'd1);
        repeat (3) @(negedge i_clk);
        checkOutput({tag, "_done_once"}, 64'(done_count - d0), 64'd1);
        checkOutput({tag, "_txn_count"}, 64'(rec_op.size()), 64'(exp_op.size()));
        for (int i = 0; i < rec_op.size() && i < exp_op.size(); i++) begin
            checkOutput($sformatf("%s_op%0d", tag, i), 64'(rec_op[i]), 64'(exp_op[i]));
            checkOutput($sformatf("%s_addr%0d", tag, i), 64'(rec_addr[i]), 64'(exp_addr[i]));
            checkOutput($sformatf("%s_data%0d", tag, i), 64'(rec_data[i]), 64'(exp_data[i]));
        end
        checkOutput({tag, "_words_done"}, 64'(o_words_done), 64'(exp_words));
        checkOutput({tag, "_error"}, 64'(o_error), 64'(exp_err));
        checkOutput({tag, "_aborted"}, 64'(o_aborted), 64'(exp_abort));
        checkOutput({tag, "_busy_idle"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        int en0, b0, cycles;
        $display("[TB] start");
        repeat (3) @(negedge i_clk);
        checkOutput("rst_busy", 64'(o_busy), 64'd0);
        checkOutput("rst_en", 64'(o_apb_en), 64'd0);
        checkOutput("rst_words", 64'(o_words_done), 64'd0);
        checkOutput("rst_src", 64'(o_src_addr), 64'd0);
        i_resetn = 1'b1;
        @(negedge i_clk);

        // 1) basic three-word copy
        applyStimulus("basic", 32'h100, 32'h200, 3, 32'hA5A50000, -1, -1, -1, 0);

        // 3) read error on the second word
        applyStimulus("rd_err", 32'h1000, 32'h2000, 4, 32'h11110000, 1, -1, -1, 0);

        // 2) zero-length job: done the cycle after start, no traffic, error cleared
        en0 = en_count; b0 = busy_count;
        @(negedge i_clk);
        i_start = 1'b1; i_num_words = 8'd0;
        @(negedge i_clk);
        i_start = 1'b0;
        checkOutput("zero_done", 64'(o_done), 64'd1);
        checkOutput("zero_busy", 64'(o_busy), 64'd0);
        checkOutput("zero_err_clr", 64'(o_error), 64'd0);
        @(negedge i_clk);
        checkOutput("zero_done_drop", 64'(o_done), 64'd0);
        checkOutput("zero_no_en", 64'(en_count - en0), 64'd0);
        checkOutput("zero_no_busy", 64'(busy_count - b0), 64'd0);

        // 4) abort during the first read, abort on the final word, write error
        applyStimulus("abort", 32'h300, 32'h400, 4, 32'h22220000, -1, -1, 0, 0);
        applyStimulus("abort_last", 32'h500, 32'h600, 2, 32'h33330000, -1, -1, 1, 0);
        applyStimulus("wr_err", 32'h700, 32'h800, 3, 32'h44440000, -1, 1, -1, 0);

        // 5) source address wrap plus a start issued while busy
        applyStimulus("wrap", 32'hFFFFFFFC, 32'h900, 2, 32'h55550000, -1, -1, -1, 1);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            automatic int num = int'($urandom_range(1, 6));
            automatic int sel = int'($urandom_range(0, 3));
            automatic int er = (sel == 1) ? int'($urandom_range(0, num - 1)) : -1;
            automatic int ew = (sel == 2) ? int'($urandom_range(0, num - 1)) : -1;
            automatic int ab = (sel == 3) ? int'($urandom_range(0, num - 1)) : -1;
            applyStimulus($sformatf("rand%0d", j), {$urandom} & 32'hFFFFFFFC,
                          {$urandom} & 32'hFFFFFFFC, num, $urandom, er, ew, ab, 0);
        end

        // 6) reset while waiting on a write, then a fresh job
        eng_fixed = 20;
        job_src = 32'hA00; job_dst = 32'hB00; job_num = 3; job_base = 32'h66660000;
        job_err_r = -1; job_err_w = -1; job_abort = -1; rd_idx = 0; wr_idx = 0;
        @(negedge i_clk);
        i_start = 1'b1; i_src_base = 32'hA00; i_dst_base = 32'hB00; i_num_words = 8'd3;
        @(negedge i_clk);
        i_start = 1'b0;
        cycles = 0;
        while (!(o_apb_op && !o_apb_en) && cycles < 200) begin
            @(negedge i_clk);
            cycles++;
        end
        checkOutput("rstwr_reached", 64'(o_apb_op && !o_apb_en), 64'd1);
        i_resetn = 1'b0;
        #1;
        checkOutput("rstwr_busy", 64'(o_busy), 64'd0);
        checkOutput("rstwr_op", 64'(o_apb_op), 64'd0);
        checkOutput("rstwr_wdata", 64'(o_apb_wdata), 64'd0);
        checkOutput("rstwr_dst", 64'(o_dst_addr), 64'd0);
        repeat (2) @(negedge i_clk);
        i_resetn = 1'b1;
        cycles = 0;
        while (eng_busy && cycles < 100) begin
            @(negedge i_clk);
            cycles++;
        end
        checkOutput("rstwr_engine_idle", 64'(eng_busy), 64'd0);
        checkOutput("rstwr_idle_after", 64'(o_busy), 64'd0);
        eng_fixed = 0;
        applyStimulus("post_rst", 32'hC00, 32'hD00, 3, 32'h77770000, -1, -1, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
